execute_stage_md: RTL and testbench

- Parametrised next-generation execute stage for the 5-stage RV32 pipeline; sits between the ID/EX register and the memory stage, and owns the EX/MEM pipeline register.
- Adds full RV32I branch compare (beq/bne/blt/bge/bltu/bgeu), jal/jalr target generation, and a flush input.
- Adds an iterative RV32M multiply/divide unit that stalls the front of the pipe through a StallE handshake with the hazard unit.

---
 rtl/execute_stage_md.sv | 192 +++++++++++++++++++
 tb/tb_execute_stage_md.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_md.sv
// execute_stage_md: RV32IM execute stage with forwarding, branch/jump resolution,
// an iterative mul/div unit that stalls the front of the pipe, and the EX/MEM register.
module execute_stage_md #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_ENABLE  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            ALUSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic            MulDivE,
    input  logic            FlushE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      Funct3E,
    input  logic [3:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    output logic            StallE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
    logic [1:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [2:0]      fn_q, fn_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, r_q, r_d, q_q, q_d, d_q, d_d;
    logic [XLEN-1:0] src_a, src_b_raw, src_b, alu_res, jalr_sum;
    logic [XLEN-1:0] abs_a, abs_b, s_r, s_q, s_d, step_r, step_q;
    logic [XLEN:0]   rem_sh, diff;
    logic [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN-1:0] quo, rem, mul_res, md_res;
    logic [SW-1:0]   shamt;
    logic            taken, idle, start, is_div, div_sgn, div_fast;
    logic            sgn_q, b_zero, ovf, sa, sb, ld_alu, ld_md, ld;
    always_comb begin
        src_a     = (ForwardA_E == 2'b01) ? ResultW : (ForwardA_E == 2'b10) ? ALU_ResultM : RD1_E;
        src_b_raw = (ForwardB_E == 2'b01) ? ResultW : (ForwardB_E == 2'b10) ? ALU_ResultM : RD2_E;
        src_b     = ALUSrcE ? Imm_Ext_E : src_b_raw;
        shamt     = src_b[SW-1:0];
    end
    always_comb begin
        alu_res = '0;
        case (ALUControlE)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a ^ src_b;
            4'b0101: alu_res = XLEN'($signed(src_a) < $signed(src_b));
            4'b0110: alu_res = XLEN'(src_a < src_b);
            4'b0111: alu_res = src_a << shamt;
            4'b1000: alu_res = src_a >> shamt;
            4'b1001: alu_res = $signed(src_a) >>> shamt;
            4'b1010: alu_res = src_b;
            default: alu_res = '0;
        endcase
    end
    always_comb begin
        taken = (Funct3E == 3'b000) ? (src_a == src_b_raw) :
                (Funct3E == 3'b001) ? (src_a != src_b_raw) :
                (Funct3E == 3'b100) ? ($signed(src_a) < $signed(src_b_raw)) :
                (Funct3E == 3'b101) ? ($signed(src_a) >= $signed(src_b_raw)) :
                (Funct3E == 3'b110) ? (src_a < src_b_raw) :
                (Funct3E == 3'b111) ? (src_a >= src_b_raw) : 1'b0;
        jalr_sum  = src_a + Imm_Ext_E;
        PCSrcE    = ValidE & ~FlushE & ~MulDivE & (JumpE | (BranchE & taken));
        PCTargetE = JalrE ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : PCE + Imm_Ext_E;
    end
    // The first restoring-division step runs in the start cycle on the live operands.
    always_comb begin
        idle     = state_q == S_IDLE;
        start    = idle & ValidE & MulDivE & ~FlushE;
        is_div   = Funct3E[2] && (DIV_ENABLE != 0);
        div_sgn  = ~Funct3E[0];
        abs_a    = (div_sgn & src_a[XLEN-1]) ? -src_a : src_a;
        abs_b    = (div_sgn & src_b_raw[XLEN-1]) ? -src_b_raw : src_b_raw;
        div_fast = (src_b_raw == '0) || (div_sgn && src_a == MIN_NEG && src_b_raw == '1);
        s_r      = idle ? '0 : r_q;
        s_q      = idle ? abs_a : q_q;
        s_d      = idle ? abs_b : d_q;
        rem_sh   = {s_r, s_q[XLEN-1]};
        diff     = rem_sh - {1'b0, s_d};
        step_r   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        step_q   = {s_q[XLEN-2:0], ~diff[XLEN]};
        StallE   = rst_n & (start | ((state_q == S_MUL || state_q == S_DIV) & ~FlushE));
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fn_d    = fn_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        if (idle) begin
            if (start) begin
                fn_d    = Funct3E;
                a_d     = src_a;
                b_d     = src_b_raw;
                r_d     = step_r;
                q_d     = step_q;
                d_d     = abs_b;
                state_d = !is_div ? ((MUL_LATENCY == 1) ? S_DONE : S_MUL) : div_fast ? S_DONE : S_DIV;
                cnt_d   = is_div ? 8'(XLEN - 2) : 8'(MUL_LATENCY - 2);
            end
        end else if (FlushE || state_q == S_DONE) begin
            state_d = S_IDLE;
        end else begin
            if (state_q == S_DIV) begin
                r_d = step_r;
                q_d = step_q;
            end
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == '0) state_d = S_DONE;
        end
    end
    always_comb begin
        sgn_q   = ~fn_q[0];
        b_zero  = b_q == '0;
        ovf     = sgn_q && a_q == MIN_NEG && b_q == '1;
        quo     = b_zero ? '1 : ovf ? a_q : (sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -q_q : q_q;
        rem     = b_zero ? a_q : ovf ? '0 : (sgn_q & a_q[XLEN-1]) ? -r_q : r_q;
        sa      = fn_q[1:0] == 2'b01 || fn_q[1:0] == 2'b10;
        sb      = fn_q[1:0] == 2'b01;
        ma      = {{XLEN{sa & a_q[XLEN-1]}}, a_q};
        mb      = {{XLEN{sb & b_q[XLEN-1]}}, b_q};
        prod    = ma * mb;
        mul_res = (fn_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        md_res  = !fn_q[2] ? mul_res : (DIV_ENABLE == 0) ? '0 : fn_q[1] ? rem : quo;
        ld_alu  = ValidE & ~FlushE & ~StallE & (state_q != S_DONE);
        ld_md   = (state_q == S_DONE) & ~FlushE;
        ld      = ld_alu | ld_md;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fn_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 2'b00;
            RD_M        <= 5'd0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fn_q        <= fn_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            RegWriteM   <= ld & RegWriteE;
            MemWriteM   <= ld & MemWriteE;
            ResultSrcM  <= ld ? ResultSrcE : 2'b00;
            RD_M        <= ld ? RD_E : 5'd0;
            PCPlus4M    <= ld ? PCPlus4E : '0;
            WriteDataM  <= ld ? src_b_raw : '0;
            ALU_ResultM <= ld_md ? md_res : ld_alu ? alu_res : '0;
        end
    end
endmodule

// File: tb/tb_execute_stage_md.sv
// tb_execute_stage_md: directed bench with a writeback scoreboard for execute_stage_md.
module tb_execute_stage_md;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, XOR = 4'b0100;
    typedef struct {
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        cw;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE, MulDivE, FlushE;
    logic [1:0]  ResultSrcE, ForwardA_E, ForwardB_E;
    logic [2:0]  Funct3E;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic        StallE, PCSrcE, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    execute_stage_md dut (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .MulDivE(MulDivE),
        .FlushE(FlushE), .ResultSrcE(ResultSrcE), .Funct3E(Funct3E), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ResultW(ResultW), .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic want(input logic [31:0] res, input logic [4:0] rd, input logic [31:0] wd, input logic cw);
        exp_t e;
        e.res = res;
        e.rd  = rd;
        e.wd  = wd;
        e.cw  = cw;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (RegWriteM === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected got=rd%0d/%h exp=none", RD_M, ALU_ResultM);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wb_res", ALU_ResultM, e.res);
                chk("wb_rd", {27'd0, RD_M}, {27'd0, e.rd});
                if (e.cw) chk("wb_wd", WriteDataM, e.wd);
            end
        end
    endtask

    task automatic op(input logic md, input logic [2:0] f3, input logic [3:0] alu,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        ValidE = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b0; ALUSrcE = 1'b0;
        BranchE = 1'b0; JumpE = 1'b0; JalrE = 1'b0; MulDivE = md; FlushE = 1'b0;
        ResultSrcE = 2'b00; Funct3E = f3; ALUControlE = alu; RD1_E = a; RD2_E = b;
        Imm_Ext_E = 32'd0; PCE = 32'h100; PCPlus4E = 32'h104; RD_E = rd;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    endtask

    task automatic nop();
        op(1'b0, 3'b000, ADD, 32'd0, 32'd0, 5'd0);
        ValidE = 1'b0;
        RegWriteE = 1'b0;
    endtask

    task automatic run_md(input string tag, input int exp_n);
        int n;
        n = 0;
        #1;
        while (StallE === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_stalls"}, n, exp_n);
        tick();
        chk({tag, "_wb"}, {31'd0, RegWriteM}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ResultW = 32'd0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rw", {31'd0, RegWriteM}, 32'd0);
        chk("rst_alu", ALU_ResultM, 32'd0);
        chk("rst_rd", {27'd0, RD_M}, 32'd0);
        chk("rst_stall", {31'd0, StallE}, 32'd0);
        rst_n = 1'b1;
        op(1'b0, 3'b000, ADD, 32'd3, 32'd4, 5'd1); want(32'd7, 5'd1, 32'd4, 1'b1); tick();
        op(1'b0, 3'b000, ADD, 32'd5, 32'd99, 5'd2); ForwardB_E = 2'b10;
        want(32'd12, 5'd2, 32'd7, 1'b1); tick();
        chk("fwd_rw", {31'd0, RegWriteM}, 32'd1);
        op(1'b0, 3'b000, ADD, 32'd1, 32'd9, 5'd3); ForwardA_E = 2'b01; ResultW = 32'd100;
        ALUSrcE = 1'b1; Imm_Ext_E = 32'd23; want(32'd123, 5'd3, 32'd9, 1'b1); tick();
        op(1'b0, 3'b000, SUB, 32'd40, 32'd3, 5'd4); ForwardA_E = 2'b11; ForwardB_E = 2'b11;
        want(32'd37, 5'd4, 32'd3, 1'b1); tick();
        op(1'b0, 3'b000, XOR, 32'hF0F0, 32'hFF00, 5'd6); want(32'h0FF0, 5'd6, 32'hFF00, 1'b1); tick();
        op(1'b0, 3'b000, ADD, 32'd8, 32'hAB, 5'd0); RegWriteE = 1'b0; MemWriteE = 1'b1; tick();
        chk("st_mw", {31'd0, MemWriteM}, 32'd1);
        chk("st_wd", WriteDataM, 32'hAB);
        op(1'b0, 3'b000, ADD, 32'd1, 32'd1, 5'd7); ValidE = 1'b0; tick();
        chk("bub_rw", {31'd0, RegWriteM}, 32'd0);
        chk("bub_alu", ALU_ResultM, 32'd0);
        op(1'b0, 3'b100, ADD, 32'hFFFFFFFF, 32'd1, 5'd0); RegWriteE = 1'b0; BranchE = 1'b1;
        Imm_Ext_E = 32'h20; #1;
        chk("blt_taken", {31'd0, PCSrcE}, 32'd1);
        chk("br_target", PCTargetE, 32'h120);
        Funct3E = 3'b110; #1;
        chk("bltu_not", {31'd0, PCSrcE}, 32'd0);
        Funct3E = 3'b010; #1;
        chk("f3_010_not", {31'd0, PCSrcE}, 32'd0);
        Funct3E = 3'b000; RD1_E = 32'd1; #1;
        chk("beq_taken", {31'd0, PCSrcE}, 32'd1);
        FlushE = 1'b1; #1;
        chk("beq_flushed", {31'd0, PCSrcE}, 32'd0);
        FlushE = 1'b0; BranchE = 1'b0; JumpE = 1'b1; Imm_Ext_E = 32'd2; #1;
        chk("jal_target", PCTargetE, 32'h102);
        JalrE = 1'b1; RD1_E = 32'h1003; #1;
        chk("jalr_target", PCTargetE, 32'h1004);
        chk("jalr_taken", {31'd0, PCSrcE}, 32'd1);
        MulDivE = 1'b1; #1;
        chk("md_no_redirect", {31'd0, PCSrcE}, 32'd0);
        nop(); tick();
        op(1'b1, 3'b011, ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5); want(32'hFFFFFFFE, 5'd5, 32'd0, 1'b0);
        run_md("mulhu", 2);
        op(1'b1, 3'b000, ADD, 32'hFFFFFFFD, 32'd7, 5'd6); want(32'hFFFFFFEB, 5'd6, 32'd0, 1'b0);
        run_md("mul", 2);
        op(1'b1, 3'b001, ADD, 32'hFFFFFFFE, 32'd3, 5'd7); want(32'hFFFFFFFF, 5'd7, 32'd0, 1'b0);
        run_md("mulh", 2);
        op(1'b1, 3'b010, ADD, 32'hFFFFFFFF, 32'd2, 5'd8); want(32'hFFFFFFFF, 5'd8, 32'd0, 1'b0);
        run_md("mulhsu", 2);
        op(1'b1, 3'b011, ADD, 32'hFFFFFFFF, 32'd2, 5'd9); want(32'd1, 5'd9, 32'd0, 1'b0);
        run_md("mulhu2", 2);
        op(1'b1, 3'b100, ADD, 32'hFFFFFFF9, 32'd2, 5'd10); want(32'hFFFFFFFD, 5'd10, 32'd0, 1'b0);
        run_md("div", 32);
        op(1'b1, 3'b110, ADD, 32'hFFFFFFF9, 32'd2, 5'd11); want(32'hFFFFFFFF, 5'd11, 32'd0, 1'b0);
        run_md("rem", 32);
        op(1'b1, 3'b101, ADD, 32'd100, 32'd7, 5'd12); want(32'd14, 5'd12, 32'd0, 1'b0);
        run_md("divu", 32);
        op(1'b1, 3'b111, ADD, 32'd100, 32'd7, 5'd13); want(32'd2, 5'd13, 32'd0, 1'b0);
        run_md("remu", 32);
        op(1'b1, 3'b101, ADD, 32'd5, 32'd0, 5'd14); want(32'hFFFFFFFF, 5'd14, 32'd0, 1'b0);
        run_md("divu0", 1);
        op(1'b1, 3'b111, ADD, 32'd5, 32'd0, 5'd15); want(32'd5, 5'd15, 32'd0, 1'b0);
        run_md("remu0", 1);
        op(1'b1, 3'b110, ADD, 32'h80000000, 32'hFFFFFFFF, 5'd16); want(32'd0, 5'd16, 32'd0, 1'b0);
        run_md("rem_ovf", 1);
        op(1'b1, 3'b100, ADD, 32'h80000000, 32'hFFFFFFFF, 5'd17); want(32'h80000000, 5'd17, 32'd0, 1'b0);
        run_md("div_ovf", 1);
        op(1'b1, 3'b101, ADD, 32'd100, 32'd7, 5'd18); #1;
        for (int i = 0; i < 9; i++) tick();
        chk("fl_busy", {31'd0, StallE}, 32'd1);
        FlushE = 1'b1; #1;
        chk("fl_stall", {31'd0, StallE}, 32'd0);
        tick();
        chk("fl_rw", {31'd0, RegWriteM}, 32'd0);
        chk("fl_alu", ALU_ResultM, 32'd0);
        op(1'b0, 3'b000, ADD, 32'd20, 32'd22, 5'd19); want(32'd42, 5'd19, 32'd22, 1'b1); #1;
        chk("fl_nostall", {31'd0, StallE}, 32'd0);
        tick();
        chk("fl_add_wb", {31'd0, RegWriteM}, 32'd1);
        op(1'b0, 3'b000, ADD, 32'd8, 32'd9, 5'd20); want(32'd17, 5'd20, 32'd9, 1'b1); tick();
        rst_n = 1'b0; #1;
        chk("ars_alu", ALU_ResultM, 32'd0);
        chk("ars_rd", {27'd0, RD_M}, 32'd0);
        chk("ars_wd", WriteDataM, 32'd0);
        rst_n = 1'b1;
        op(1'b1, 3'b011, ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21); #1;
        tick();
        chk("rs_busy", {31'd0, StallE}, 32'd1);
        rst_n = 1'b0; #1;
        chk("rs_stall", {31'd0, StallE}, 32'd0);
        chk("rs_rw", {31'd0, RegWriteM}, 32'd0);
        chk("rs_alu", ALU_ResultM, 32'd0);
        nop(); #1;
        rst_n = 1'b1;
        op(1'b0, 3'b000, ADD, 32'd1, 32'd2, 5'd22); want(32'd3, 5'd22, 32'd2, 1'b1); #1;
        chk("rs_nostall", {31'd0, StallE}, 32'd0);
        tick();
        chk("rs_add_wb", {31'd0, RegWriteM}, 32'd1);
        nop(); tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
